// File: rtl/pipe_ctrl_decoder.sv
// ID-stage main decoder: registered ID/EX control fields, bubble insertion, illegal-opcode pulse and HALT drain FSM.
// Latency 1 clk Opcode->ID/EX; stall/flush load a bubble, no internal backpressure.
module pipe_ctrl_decoder #(
  parameter int OPCODE_W     = 7,
  parameter int ALUOP_W      = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                valid_in,
  input  logic                stall,
  input  logic                flush,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                Branch,
  output logic                valid_out,
  output logic                illegal_op,
  output logic                pc_hold,
  output logic                halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(7'b1110101);

  localparam logic [ALUOP_W-1:0] ALUOP_MEM = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALUOP_ALU = ALUOP_W'(2);

  typedef struct packed {
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               valid;
  } ctrl_t;

  logic [1:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  ctrl_t            ctrl_q, ctrl_nxt, dec;
  logic             illegal_q, illegal_nxt;
  logic             is_halt, is_illegal, issue;

  // Pure opcode decode; gating by valid/stall/flush/FSM happens below.
  always_comb begin
    dec        = '0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (Opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_ALU;
        dec.valid     = 1'b1;
      end
      OP_I: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_ALU;
        dec.valid     = 1'b1;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_op     = ALUOP_MEM;
        dec.valid      = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALUOP_MEM;
        dec.valid     = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_BR;
        dec.valid  = 1'b1;
      end
      OP_HALT: begin
        dec.valid = 1'b1;
        is_halt   = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

  assign issue       = valid_in & ~stall & ~flush & (state_q == ST_RUN);
  assign ctrl_nxt    = issue ? dec : '0;
  assign illegal_nxt = issue & is_illegal;

  // Once HALT leaves ID, only younger instructions remain in ID, so DRAIN ignores all inputs.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (issue && is_halt) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_nxt = ST_HALTED;
        else             cnt_nxt   = cnt_q - 1'b1;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      ctrl_q    <= ctrl_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  assign ALUSrc     = ctrl_q.alu_src;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign RegWrite   = ctrl_q.reg_write;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign ALUOp      = ctrl_q.alu_op;
  assign Branch     = ctrl_q.branch;
  assign valid_out  = ctrl_q.valid;
  assign illegal_op = illegal_q;
  assign pc_hold    = (state_q != ST_RUN);
  assign halted     = (state_q == ST_HALTED);

  a_illegal_is_bubble: assert property (@(posedge clk) disable iff (!rst_n) illegal_op |-> !valid_out);
  a_halted_holds_pc:   assert property (@(posedge clk) disable iff (!rst_n) halted |-> pc_hold);

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Directed bench for pipe_ctrl_decoder: stimulus pushes expected ID/EX vectors, a negedge monitor pops and compares.
module tb_pipe_ctrl_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Opcode;
  logic       valid_in, stall, flush;
  logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0] ALUOp;
  logic       valid_out, illegal_op, pc_hold, halted;

  pipe_ctrl_decoder #(.OPCODE_W(7), .ALUOP_W(2), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .valid_in(valid_in),
    .stall(stall), .flush(flush), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUOp(ALUOp), .Branch(Branch), .valid_out(valid_out),
    .illegal_op(illegal_op), .pc_hold(pc_hold), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_HALT = 7'b1110101;
  localparam logic [6:0] OP_BAD = 7'h7F;

  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp[1:0],Branch,valid_out,illegal_op,pc_hold,halted}
  localparam logic [11:0] R_O    = 12'b0010_0100_1000;
  localparam logic [11:0] I_O    = 12'b1010_0100_1000;
  localparam logic [11:0] LW_O   = 12'b1111_0000_1000;
  localparam logic [11:0] SW_O   = 12'b1000_1000_1000;
  localparam logic [11:0] BEQ_O  = 12'b0000_0011_1000;
  localparam logic [11:0] HALT_O = 12'b0000_0000_1010;
  localparam logic [11:0] ILL_O  = 12'b0000_0000_0100;
  localparam logic [11:0] BUB_O  = 12'b0000_0000_0000;
  localparam logic [11:0] DRN_O  = 12'b0000_0000_0010;
  localparam logic [11:0] HLT_O  = 12'b0000_0000_0011;

  typedef struct {
    logic [11:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [11:0] outv();
    return {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch,
            valid_out, illegal_op, pc_hold, halted};
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    got = outv();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input logic [6:0] op, input logic v, input logic s, input logic f,
                      input logic [11:0] exp, input string tag);
    exp_t e;
    Opcode   = op;
    valid_in = v;
    stall    = s;
    flush    = f;
    @(posedge clk);
    #1;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check(tag, BUB_O);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, BUB_O);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, e.exp);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; Opcode = '0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    check("reset_init", BUB_O);
    @(negedge clk);
    rst_n = 1'b1;

    step(OP_R,   1, 0, 0, R_O,   "dec_r");
    step(OP_I,   1, 0, 0, I_O,   "dec_i");
    step(OP_LW,  1, 0, 0, LW_O,  "dec_lw");
    step(OP_SW,  1, 0, 0, SW_O,  "dec_sw");
    step(OP_BEQ, 1, 0, 0, BEQ_O, "dec_beq");
    step(OP_LW,  0, 0, 0, BUB_O, "no_valid");
    step(OP_LW,  1, 1, 0, BUB_O, "lw_stall");
    step(OP_BEQ, 1, 0, 1, BUB_O, "beq_flush");
    step(OP_BAD, 1, 0, 0, ILL_O, "illegal");
    step(OP_BAD, 0, 0, 0, BUB_O, "illegal_end");
    step(OP_BAD, 1, 1, 0, BUB_O, "illegal_stall");
    step(OP_BAD, 1, 0, 1, BUB_O, "illegal_flush");
    step(OP_LW,  1, 0, 0, LW_O,  "dec_lw2");

    // Outputs hold LW here, so zeros right after rst_n falls prove the reset is asynchronous.
    pulse_reset("async_reset");
    step(OP_SW,   1, 0, 0, SW_O,   "after_reset1");

    step(OP_HALT, 1, 0, 1, BUB_O,  "halt_flush");
    step(OP_R,    1, 0, 0, R_O,    "run_after_flush");
    step(OP_HALT, 1, 1, 0, BUB_O,  "halt_stall");
    step(OP_HALT, 1, 0, 0, HALT_O, "halt");
    step(OP_R,    1, 0, 0, DRN_O,  "drain_1");
    step(OP_BEQ,  1, 1, 1, DRN_O,  "drain_2");
    step(OP_BAD,  1, 0, 0, HLT_O,  "halted");
    step(OP_R,    1, 0, 0, HLT_O,  "halted_r");
    step(OP_BAD,  1, 0, 0, HLT_O,  "halted_bad");

    pulse_reset("reset_halted");
    step(OP_HALT, 1, 0, 0, HALT_O, "halt2");
    step(OP_R,    1, 0, 0, DRN_O,  "drain_cnt1");
    pulse_reset("reset_in_drain");
    step(OP_R,    1, 0, 0, R_O,    "resume_r");
    step(OP_I,    1, 0, 0, I_O,    "resume_i");
    step(OP_R,    0, 0, 0, BUB_O,  "resume_idle");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
